// File: rtl/rackbus_pkg.sv
// Shared types and default constants for the rackbus RX sync-lock supervisor.
package rackbus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } rackbus_lock_state_t;

  localparam int RACKBUS_SYNC_PERIOD = 4;
  localparam int RACKBUS_LOCK_COUNT  = 16;

endpackage

// File: rtl/rackbus_sync_flywheel.sv
// Free-running frame phase counter; reload puts the current cycle at phase 0.
module rackbus_sync_flywheel
  import rackbus_pkg::*;
#(
  parameter int PERIOD = RACKBUS_SYNC_PERIOD
) (
  input  logic                      rxclk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      reload,
  output logic [$clog2(PERIOD)-1:0] phase,
  output logic                      expected
);

  localparam int PW = $clog2(PERIOD);

  logic [PW-1:0] phase_reg;

  // PERIOD is a power of two, so the natural wrap of the adder is the modulo.
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= '0;
    end else if (clear) begin
      phase_reg <= '0;
    end else if (reload) begin
      phase_reg <= PW'(1);
    end else begin
      phase_reg <= phase_reg + 1'b1;
    end
  end

  assign phase    = phase_reg;
  assign expected = (phase_reg == '0);

endmodule

// File: rtl/rackbus_sync_lock_ctrl.sv
// Frame-sync lock supervisor: acquires lock on a periodic sync pulse, flywheels a
// regenerated sync, counts sync errors and requests re-alignment on loss of lock.
module rackbus_sync_lock_ctrl
  import rackbus_pkg::*;
#(
  parameter int PERIOD      = RACKBUS_SYNC_PERIOD,
  parameter int LOCK_COUNT  = RACKBUS_LOCK_COUNT,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                      rxclk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      sync_i,
  input  logic                      err_clr_i,
  output logic [$clog2(PERIOD)-1:0] phase_o,
  output logic                      sync_o,
  output logic                      locked_o,
  output logic [1:0]                state_o,
  output logic [ERR_CNT_W-1:0]      err_cnt_o,
  output logic                      relock_o
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);

  rackbus_lock_state_t   state_reg;
  logic [GW-1:0]         good_cnt_reg;
  logic [BW-1:0]         bad_run_reg;
  logic [ERR_CNT_W-1:0]  err_cnt_reg;
  logic                  relock_reg;

  logic                  expected;
  logic                  fly_clear;
  logic                  fly_reload;
  logic                  good;
  logic                  missing;
  logic                  extra;
  logic                  bad;
  logic [BW-1:0]         run_inc;

  assign good    = sync_i && expected;
  assign missing = expected && !sync_i;
  assign extra   = sync_i && !expected;
  assign bad     = missing || extra;
  assign run_inc = bad_run_reg + 1'b1;

  // Phase is held at 0 while idle; a new candidate pulse re-anchors it.
  assign fly_clear  = !en_i || (state_reg == IDLE);
  assign fly_reload = en_i && (((state_reg == SEARCH) && sync_i) ||
                               ((state_reg == VERIFY) && extra));

  rackbus_sync_flywheel #(
    .PERIOD (PERIOD)
  ) u_flywheel (
    .rxclk    (rxclk),
    .rst_n    (rst_n),
    .clear    (fly_clear),
    .reload   (fly_reload),
    .phase    (phase_o),
    .expected (expected)
  );

  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      good_cnt_reg <= '0;
      bad_run_reg  <= '0;
      err_cnt_reg  <= '0;
      relock_reg   <= 1'b0;
    end else begin
      relock_reg <= 1'b0;
      if (!en_i) begin
        state_reg    <= IDLE;
        good_cnt_reg <= '0;
        bad_run_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: state_reg <= SEARCH;
          SEARCH: begin
            if (sync_i) begin
              state_reg    <= VERIFY;
              good_cnt_reg <= '0;
            end
          end
          VERIFY: begin
            if (good) begin
              if (good_cnt_reg == GW'(LOCK_COUNT - 1)) begin
                state_reg   <= LOCKED;
                bad_run_reg <= '0;
              end else begin
                good_cnt_reg <= good_cnt_reg + 1'b1;
              end
            end else if (extra) begin
              good_cnt_reg <= '0;
            end else if (missing) begin
              state_reg <= SEARCH;
            end
          end
          LOCKED: begin
            if (good) begin
              bad_run_reg <= '0;
            end else if (bad) begin
              if (err_cnt_reg != '1) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
              end
              if (run_inc == BW'(UNLOCK_ERRS)) begin
                state_reg    <= SEARCH;
                bad_run_reg  <= '0;
                good_cnt_reg <= '0;
                relock_reg   <= 1'b1;
              end else begin
                bad_run_reg <= run_inc;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
      // Clear wins over any increment scheduled above.
      if (err_clr_i) begin
        err_cnt_reg <= '0;
      end
    end
  end

  assign locked_o  = (state_reg == LOCKED);
  assign sync_o    = locked_o && expected;
  assign state_o   = state_reg;
  assign err_cnt_o = err_cnt_reg;
  assign relock_o  = relock_reg;

endmodule

// File: tb/tb_rackbus_sync_lock_ctrl.sv
// Directed bench for rackbus_sync_lock_ctrl with a cycle-level reference model.
module tb_rackbus_sync_lock_ctrl;

  localparam int P    = 4;
  localparam int LC   = 16;
  localparam int UE   = 2;
  localparam int EW   = 4;
  localparam int EMAX = (1 << EW) - 1;

  logic          rxclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_i = 1'b0;
  logic          sync_i = 1'b0;
  logic          err_clr_i = 1'b0;
  logic [1:0]    phase_o;
  logic          sync_o;
  logic          locked_o;
  logic [1:0]    state_o;
  logic [EW-1:0] err_cnt_o;
  logic          relock_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  // Reference model: phase is expressed as distance from the last anchor cycle.
  int m_t, m_anchor, m_st, m_good, m_run, m_err, m_ph;
  bit m_relock, m_exp, m_gd, m_ms, m_xt;

  always #5 rxclk = ~rxclk;

  rackbus_sync_lock_ctrl #(
    .PERIOD      (P),
    .LOCK_COUNT  (LC),
    .UNLOCK_ERRS (UE),
    .ERR_CNT_W   (EW)
  ) dut (
    .rxclk     (rxclk),
    .rst_n     (rst_n),
    .en_i      (en_i),
    .sync_i    (sync_i),
    .err_clr_i (err_clr_i),
    .phase_o   (phase_o),
    .sync_o    (sync_o),
    .locked_o  (locked_o),
    .state_o   (state_o),
    .err_cnt_o (err_cnt_o),
    .relock_o  (relock_o)
  );

  function automatic int m_phase();
    return (m_t - m_anchor) % P;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_anchor = 0; m_st = 0; m_good = 0; m_run = 0; m_err = 0; m_relock = 0;
  endtask

  task automatic model_step();
    m_ph  = m_phase();
    m_exp = (m_ph == 0);
    m_gd  = sync_i && m_exp;
    m_ms  = m_exp && !sync_i;
    m_xt  = sync_i && !m_exp;
    m_relock = 0;
    if (!en_i) begin
      m_st = 0; m_good = 0; m_run = 0; m_anchor = m_t + 1;
    end else begin
      case (m_st)
        0: begin m_st = 1; m_anchor = m_t + 1; end
        1: if (sync_i) begin m_st = 2; m_good = 0; m_anchor = m_t; end
        2: begin
          if (m_gd) begin
            if (m_good == LC - 1) begin m_st = 3; m_run = 0; end
            else m_good++;
          end else if (m_xt) begin
            m_anchor = m_t; m_good = 0;
          end else if (m_ms) begin
            m_st = 1;
          end
        end
        default: begin
          if (m_gd) m_run = 0;
          else if (m_ms || m_xt) begin
            m_err = (m_err + 1 > EMAX) ? EMAX : m_err + 1;
            m_run++;
            if (m_run == UE) begin m_st = 1; m_run = 0; m_good = 0; m_relock = 1; end
          end
        end
      endcase
    end
    if (err_clr_i) m_err = 0;
    m_t++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge rxclk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  always @(negedge rxclk) begin
    if (chk_on) begin
      check("phase_o", int'(phase_o), m_phase());
      check("state_o", int'(state_o), m_st);
      check("locked_o", int'(locked_o), (m_st == 3) ? 1 : 0);
      check("sync_o", int'(sync_o), (m_st == 3 && m_phase() == 0) ? 1 : 0);
      check("err_cnt_o", int'(err_cnt_o), m_err);
      check("relock_o", int'(relock_o), int'(m_relock));
    end
  end

  task automatic tick(bit en, bit s, bit clr);
    en_i = en; sync_i = s; err_clr_i = clr;
    @(posedge rxclk);
    @(negedge rxclk);
    cyc++;
  endtask

  task automatic slot(bit s);
    tick(1, s, 0);
    repeat (P - 1) tick(1, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge rxclk);
    check("reset_state", int'(state_o), 0);
    check("reset_err", int'(err_cnt_o), 0);
    check("reset_phase", int'(phase_o), 0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    cyc = 0;

    // Acquire: pulses at cycles 10, 14, ..., 74.
    repeat (10) tick(1, 0, 0);
    for (int k = 0; k < 17; k++) begin
      tick(1, 1, 0);
      if (k == 0) check("verify_at_11", int'(state_o), 2);
      if (k == 15) check("unlocked_at_71", int'(locked_o), 0);
      if (k == 16) begin
        check("locked_at_75", int'(locked_o), 1);
        check("err_after_lock", int'(err_cnt_o), 0);
      end
      repeat (P - 1) tick(1, 0, 0);
    end
    check("sync_o_slot_78", int'(sync_o), 1);
    $display("acquire: locked at cycle 75, cycle now %0d", cyc);

    // Single miss while locked.
    slot(1); slot(1);
    check("sync_o_in_missing_slot", int'(sync_o), 1);
    slot(0);
    check("miss_err", int'(err_cnt_o), 1);
    check("miss_still_locked", int'(locked_o), 1);
    slot(1); slot(1);
    $display("single miss: err_cnt=%0d locked=%0d", err_cnt_o, locked_o);

    // Clear on a quiet cycle, then slip the train by one cycle.
    tick(1, 1, 0);
    tick(1, 0, 1);
    check("clr_quiet", int'(err_cnt_o), 0);
    check("clr_keeps_lock", int'(locked_o), 1);
    tick(1, 0, 0); tick(1, 0, 0);
    tick(1, 0, 0);
    check("slip_first_bad_locked", int'(locked_o), 1);
    tick(1, 1, 0);
    check("slip_to_search", int'(state_o), 1);
    check("slip_relock", int'(relock_o), 1);
    check("slip_err", int'(err_cnt_o), 2);
    tick(1, 0, 0);
    check("relock_one_cycle", int'(relock_o), 0);
    tick(1, 0, 0); tick(1, 0, 0);
    for (int k = 0; k < 17; k++) begin
      tick(1, 1, 0);
      if (k == 15) check("slip_not_yet_locked", int'(locked_o), 0);
      if (k == 16) check("slip_relocked", int'(locked_o), 1);
      repeat (P - 1) tick(1, 0, 0);
    end
    $display("phase slip: relocked, err_cnt=%0d", err_cnt_o);

    // Enable low in LOCKED, then extra pulse during VERIFY.
    tick(0, 0, 0);
    check("en_low_idle", int'(state_o), 0);
    check("en_low_err_kept", int'(err_cnt_o), 2);
    tick(1, 0, 0);
    check("en_high_search", int'(state_o), 1);
    tick(1, 0, 0); tick(1, 0, 0);
    for (int k = 0; k < 8; k++) slot(1);
    tick(1, 1, 0);
    tick(1, 0, 0);
    tick(1, 1, 0);
    check("extra_stays_verify", int'(state_o), 2);
    check("extra_reload_phase", int'(phase_o), 1);
    for (int k = 0; k < 16; k++) begin
      repeat (P - 1) tick(1, 0, 0);
      tick(1, 1, 0);
      if (k == 14) check("extra_not_yet_locked", int'(locked_o), 0);
      if (k == 15) check("extra_locked", int'(locked_o), 1);
    end
    $display("extra in verify: locked=%0d at cycle %0d", locked_o, cyc);

    // Saturation with alternating miss/good, then clear against a bad event.
    repeat (P - 1) tick(1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      slot(0);
      slot(1);
    end
    check("sat_err", int'(err_cnt_o), 15);
    check("sat_locked", int'(locked_o), 1);
    tick(1, 0, 1);
    check("clr_beats_inc", int'(err_cnt_o), 0);
    check("clr_bad_locked", int'(locked_o), 1);
    repeat (P - 1) tick(1, 0, 0);
    slot(1);
    $display("saturation: err_cnt cleared, locked=%0d", locked_o);

    // Asynchronous reset mid-LOCKED.
    check("pre_reset_locked", int'(locked_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_state", int'(state_o), 0);
    check("areset_locked", int'(locked_o), 0);
    check("areset_phase", int'(phase_o), 0);
    check("areset_err", int'(err_cnt_o), 0);
    check("areset_sync", int'(sync_o), 0);
    @(negedge rxclk);
    rst_n = 1'b1;
    tick(1, 0, 0);
    check("post_reset_search", int'(state_o), 1);
    tick(1, 0, 0);
    $display("async reset: returned to idle and restarted search");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
